// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_pkg
//  Brief    : Shared constants and helpers for the load/store unit: access
//             width encodings, FSM state codes, default bus wait limit and
//             lane/byte-enable helper functions.
//  Revision : 1.0  initial release
// ============================================================================
package load_store_unit_pkg;

    // Access width encodings on WL (3 is treated as word)
    localparam logic [1:0] c_WL_BYTE = 2'd0;
    localparam logic [1:0] c_WL_HALF = 2'd1;
    localparam logic [1:0] c_WL_WORD = 2'd2;

    // Default number of REQ cycles without bus_ack before a bus error
    localparam int c_WAIT_LIMIT_DEFAULT = 255;

    // FSM state codes
    localparam int         c_STATE_W  = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // True when the low address bits do not match the access width
    function automatic logic is_misaligned(input logic [1:0] wl, input logic [1:0] lane);
        logic mis;
        case (wl)
            c_WL_BYTE: mis = 1'b0;
            c_WL_HALF: mis = lane[0];
            default:   mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

    // Byte enables; loads use the same enables as stores
    function automatic logic [3:0] byte_enables(input logic [1:0] wl, input logic [1:0] lane);
        logic [3:0] be;
        case (wl)
            c_WL_BYTE: be = 4'b0001 << lane;
            c_WL_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            c_WL_WORD: be = 4'b1111;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data across every lane it may land on
    function automatic logic [31:0] store_lanes(input logic [1:0] wl, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (wl)
            c_WL_BYTE: lanes = {4{wdata[7:0]}};
            c_WL_HALF: lanes = {2{wdata[15:0]}};
            default:   lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_load_extend
//  Brief    : Combinational lane select and sign/zero extension of a loaded
//             memory word into a right-justified 32-bit result.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_wl,
    input  logic [1:0]  i_lane,
    input  logic        i_sign_ext,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane and extend it to 32 bits
    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_wl)
            c_WL_BYTE: o_result = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            c_WL_HALF: o_result = {{16{i_sign_ext & w_half[15]}}, w_half};
            default:   o_result = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : Single-outstanding load/store unit. Accepts a decode-stage
//             load/store in IDLE, issues one word-aligned bus request with
//             byte enables, waits for bus_ack or times out, and returns the
//             extended load result in DONE.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WAIT_LIMIT = c_WAIT_LIMIT_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  WL,
    input  logic        extendSign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        lsu_stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter is at least 8 bits, wider only if the limit needs it
    localparam int c_CNT_W = (WAIT_LIMIT > 255) ? $clog2(WAIT_LIMIT + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_LIMIT - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;

    logic                 r_bus_req;
    logic                 r_bus_we;
    logic [31:0]          r_bus_addr;
    logic [31:0]          r_bus_wdata;
    logic [3:0]           r_bus_be;
    logic [1:0]           r_wl;
    logic                 r_sign;
    logic [1:0]           r_lane;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_rdata;
    logic                 r_bus_err;

    logic                 w_access;
    logic                 w_mis;
    logic                 w_ack;
    logic                 w_timeout;
    logic [31:0]          w_load_data;

    assign w_access  = memRead | memWrite;
    assign w_mis     = is_misaligned(WL, addr[1:0]);
    // An ack only counts while a request is actually outstanding
    assign w_ack     = r_bus_req & bus_ack;
    assign w_timeout = (r_state == c_ST_REQ) & ~bus_ack & (r_cnt == c_CNT_LAST);

    load_store_unit_load_extend u_load_extend (
        .i_word     (bus_rdata),
        .i_wl       (r_wl),
        .i_lane     (r_lane),
        .i_sign_ext (r_sign),
        .o_result   (w_load_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_access) begin
                    w_next_state = w_mis ? c_ST_DONE : c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (w_ack || w_timeout) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Combinational outputs: stall and misalignment flag, both held low in reset
    always_comb begin
        lsu_stall  = 1'b0;
        misaligned = 1'b0;
        if (!reset) begin
            case (r_state)
                c_ST_IDLE: begin
                    lsu_stall  = w_access;
                    misaligned = w_access & w_mis;
                end
                c_ST_REQ:  lsu_stall = 1'b1;
                default:   lsu_stall = 1'b0;
            endcase
        end
    end

    // Bus request latching, wait counter and load result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_be    <= 4'd0;
            r_wl        <= c_WL_BYTE;
            r_sign      <= 1'b0;
            r_lane      <= 2'd0;
            r_cnt       <= '0;
            r_rdata     <= 32'd0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_access && !w_mis) begin
                        // memWrite wins when both commands are high
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= memWrite;
                        r_bus_addr  <= {addr[31:2], 2'b00};
                        r_bus_wdata <= store_lanes(WL, wdata);
                        r_bus_be    <= byte_enables(WL, addr[1:0]);
                        r_wl        <= WL;
                        r_sign      <= extendSign;
                        r_lane      <= addr[1:0];
                        r_cnt       <= '0;
                    end else if (w_access) begin
                        r_rdata     <= 32'd0;
                    end
                end
                c_ST_REQ: begin
                    if (w_ack) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            r_rdata <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_rdata   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign bus_err   = r_bus_err;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Self-checking bench for load_store_unit: directed corner cases
//             followed by randomized loads/stores against a byte-level
//             memory model and an access-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam int c_WAIT_LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  WL;
    logic        extendSign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        lsu_stall;
    logic        misaligned;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_rdata;
    logic [31:0] mem [int];

    load_store_unit #(.WAIT_LIMIT(c_WAIT_LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .WL         (WL),
        .extendSign (extendSign),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .lsu_stall  (lsu_stall),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int idx);
        if (mem.exists(idx)) return mem[idx];
        return 32'hA5A5_0000 ^ 32'(idx);
    endfunction

    // Reference extraction: shift the word down by the byte offset, mask, extend
    function automatic logic [31:0] ref_extract(input logic [31:0] word, input int nb,
                                                input int off, input bit sgn);
        logic [31:0] v;
        logic [31:0] mask;
        if (nb == 4) return word;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v = (word >> (8 * off)) & mask;
        if (sgn && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // One complete access from IDLE back to IDLE; ack_dly < 0 means never ack
    task automatic do_access(input bit rd, input bit wr, input logic [1:0] wl, input bit sgn,
                             input logic [31:0] a, input logic [31:0] wd, input int ack_dly);
        int          nb;
        int          off;
        int          stall_cnt;
        int          exp_stall;
        bit          mis;
        bit          timed_out;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] mask;
        logic [31:0] word;
        int          idx;

        memRead    = rd;
        memWrite   = wr;
        WL         = wl;
        extendSign = sgn;
        addr       = a;
        wdata      = wd;
        #1;
        if (!rd && !wr) begin
            check_value("idle_nop_stall", 32'(lsu_stall), 32'd0);
            @(posedge clk); #1;
            return;
        end

        nb        = (wl == 2'd0) ? 1 : (wl == 2'd1) ? 2 : 4;
        mis       = (int'(a[1:0]) % nb) != 0;
        off       = int'(a[1:0]) & ~(nb - 1);
        e_be      = 4'((32'd1 << nb) - 32'd1) << off;
        mask      = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        e_wd      = 32'd0;
        for (int i = 0; i < 4 / nb; i++) e_wd = e_wd | ((wd & mask) << (8 * nb * i));
        idx       = int'(a >> 2);
        timed_out = 1'b0;
        stall_cnt = 0;

        if (lsu_stall) stall_cnt++;
        check_value("idle_stall", 32'(lsu_stall), 32'd1);
        check_value("idle_misaligned", 32'(misaligned), 32'(mis));
        check_value("idle_bus_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        addr     = $urandom;
        wdata    = $urandom;

        if (mis) begin
            exp_rdata = 32'd0;
            exp_stall = 1;
        end else begin
            timed_out = 1'b1;
            for (int k = 0; k < c_WAIT_LIMIT; k++) begin
                if (lsu_stall) stall_cnt++;
                check_value("req_bus_req", 32'(bus_req), 32'd1);
                check_value("req_bus_addr", bus_addr, {a[31:2], 2'b00});
                check_value("req_bus_we", 32'(bus_we), 32'(wr));
                check_value("req_bus_be", 32'(bus_be), 32'(e_be));
                check_value("req_bus_wdata", bus_wdata, e_wd);
                if (k == ack_dly) begin
                    word      = mem_rd(idx);
                    bus_ack   = 1'b1;
                    bus_rdata = wr ? 32'($urandom) : word;
                    @(posedge clk); #1;
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                    timed_out = 1'b0;
                    if (wr) begin
                        for (int b = 0; b < 4; b++)
                            if (e_be[b]) word[8*b +: 8] = e_wd[8*b +: 8];
                        mem[idx] = word;
                    end else begin
                        exp_rdata = ref_extract(word, nb, off, sgn);
                    end
                    break;
                end
                @(posedge clk); #1;
            end
            if (timed_out) exp_rdata = 32'd0;
            exp_stall = timed_out ? 1 + c_WAIT_LIMIT : 2 + ack_dly;
        end

        check_value("done_stall", 32'(lsu_stall), 32'd0);
        check_value("done_bus_req", 32'(bus_req), 32'd0);
        check_value("done_bus_err", 32'(bus_err), 32'(timed_out));
        check_value("done_misaligned", 32'(misaligned), 32'd0);
        check_value("done_rdata", rdata, exp_rdata);
        check_value("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        @(posedge clk); #1;
        check_value("post_bus_err", 32'(bus_err), 32'd0);
        check_value("post_stall", 32'(lsu_stall), 32'd0);
        check_value("post_rdata", rdata, exp_rdata);
    endtask

    initial begin
        int          op;
        int          r;
        n_vec      = 0;
        n_err      = 0;
        exp_rdata  = 32'd0;
        reset      = 1'b1;
        memRead    = 1'b1;
        memWrite   = 1'b0;
        WL         = 2'd2;
        extendSign = 1'b0;
        addr       = 32'h100;
        wdata      = 32'd0;
        bus_ack    = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;

        // Reset with a pending command and a stray ack
        #1;
        check_value("rst_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        check_value("rst_stall2", 32'(lsu_stall), 32'd0);
        check_value("rst_bus_req", 32'(bus_req), 32'd0);
        check_value("rst_bus_be", 32'(bus_be), 32'd0);
        check_value("rst_bus_addr", bus_addr, 32'd0);
        check_value("rst_bus_wdata", bus_wdata, 32'd0);
        check_value("rst_rdata", rdata, 32'd0);
        check_value("rst_misaligned", 32'(misaligned), 32'd0);
        check_value("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        memRead  = 1'b0;
        bus_ack  = 1'b0;

        // LW aligned, ack on first REQ cycle
        mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        do_access(1, 0, 2'd2, 0, 32'h100, 32'd0, 0);
        check_value("lw_value", rdata, 32'hDEAD_BEEF);

        // LB / LBU from the top lane
        mem[32'h103 >> 2] = 32'h8000_0000;
        do_access(1, 0, 2'd0, 1, 32'h103, 32'd0, 0);
        check_value("lb_value", rdata, 32'hFFFF_FF80);
        do_access(1, 0, 2'd0, 0, 32'h103, 32'd0, 1);
        check_value("lbu_value", rdata, 32'h0000_0080);

        // SH to upper half
        do_access(0, 1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 2);

        // Misaligned LW
        do_access(1, 0, 2'd2, 0, 32'h101, 32'd0, 0);

        // Reload a value, then a timeout must clear it
        do_access(1, 0, 2'd3, 0, 32'h100, 32'd0, 3);
        do_access(1, 0, 2'd2, 0, 32'h300, 32'd0, -1);

        // Reset while a request is outstanding, stray ack during reset
        memRead = 1'b1; WL = 2'd2; addr = 32'h400;
        @(posedge clk); #1;
        memRead = 1'b0;
        check_value("mid_bus_req", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        reset   = 1'b1;
        bus_ack = 1'b1;
        memRead = 1'b1;
        #1;
        check_value("mid_rst_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        check_value("mid_rst_bus_req", 32'(bus_req), 32'd0);
        check_value("mid_rst_bus_we", 32'(bus_we), 32'd0);
        check_value("mid_rst_bus_be", 32'(bus_be), 32'd0);
        check_value("mid_rst_bus_addr", bus_addr, 32'd0);
        check_value("mid_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        bus_ack   = 1'b0;
        memRead   = 1'b0;
        exp_rdata = 32'd0;
        mem[32'h10 >> 2] = 32'h7F65_4321;
        do_access(0, 1, 2'd0, 0, 32'h10, 32'h0000_0099, 0);
        do_access(1, 0, 2'd1, 1, 32'h12, 32'd0, 0);
        check_value("lh_after_sb", rdata, 32'h0000_7F65);

        // Randomized traffic over a small window so loads see earlier stores
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 7);
            r  = $urandom_range(0, 9);
            do_access((op >= 1 && op <= 3) || op == 7, op >= 4,
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      32'h1000 + 32'($urandom_range(0, 31)), 32'($urandom),
                      (r == 9) ? -1 : (r % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, meaning max cycles in REQ without bus_ack before bus error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 memRead  input  1  load command from decode stage.
REQ-005 memWrite  input  1  store command from decode stage.
REQ-006 WL  input  2  access width: 0 byte, 1 half, 2 word, 3 treated as word.
REQ-007 extendSign  input  1  1 sign-extend loaded byte/half, 0 zero-extend.
REQ-008 addr  input  32  byte address from ALU.
REQ-009 wdata  input  32  store data, right-justified (rs2).
REQ-010 rdata  output  32  extended load result, valid in DONE.
REQ-011 lsu_stall  output  1  pipeline hold request.
REQ-012 misaligned  output  1  one-cycle pulse on misaligned access.
REQ-013 bus_err  output  1  one-cycle pulse on bus timeout.
REQ-014 bus_req, bus_we  output  1 each  request and write-enable to data memory.
REQ-015 bus_addr  output  32  word-aligned address (addr[1:0] forced 0).
REQ-016 bus_wdata  output  32  lane-replicated store data.
REQ-017 bus_be  output  4  byte enables.
REQ-018 bus_ack  input  1  memory completion, one cycle; bus_rdata  input  32  read word valid with bus_ack.

Function
REQ-019 FSM states IDLE, REQ, DONE; only IDLE samples memRead/memWrite.
REQ-020 IDLE: memRead|memWrite -> lsu_stall=1 combinationally same cycle; aligned -> REQ; misaligned -> DONE; else stay IDLE, lsu_stall=0.
REQ-021 memRead and memWrite both high: treated as store.
REQ-022 On IDLE->REQ, bus_addr, bus_we, bus_be, bus_wdata, WL, extendSign, addr[1:0] registered; bus_req=1 from next cycle and held constant until ack or timeout.
REQ-023 bus_be: byte 1<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100; word 4'b1111; bus_be=0 for loads is not permitted -- loads use same enables.
REQ-024 bus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-025 REQ: lsu_stall=1; bus_ack -> capture extracted load data, bus_req=0 next cycle, -> DONE.
REQ-026 Load extract: byte from lane addr[1:0], half from lane addr[1]; extend to 32 bits per extendSign; word unchanged.
REQ-027 Wait counter 8+ bits, cleared on REQ entry, increments each REQ cycle without ack; reaching WAIT_LIMIT -> bus_err pulse, bus_req drops, rdata=0, -> DONE.
REQ-028 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; no bus request; misaligned=1 for the IDLE cycle; rdata=0.
REQ-029 DONE: lsu_stall=0, rdata held, inputs ignored; -> IDLE next cycle.
REQ-030 Minimum aligned latency: 3 cycles (IDLE accept, REQ with ack, DONE); rdata stable until next load capture.
REQ-031 Store completion leaves rdata unchanged.

Reset
REQ-032 reset=1 at any edge, including mid-REQ: state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, counter=0, misaligned=0, bus_err=0.
REQ-033 lsu_stall=0 during reset regardless of memRead/memWrite.
REQ-034 bus_ack arriving during or after reset with bus_req=0 is ignored.

Structure
REQ-035 WL encodings (byte/half/word), FSM state codes and default WAIT_LIMIT live in shared parameters.vh alongside existing opcode constants.
REQ-036 One sub-module natural: load_extend (combinational lane select and sign/zero extension).

Verification
REQ-037 LW addr=0x100, bus_ack on 1st REQ cycle, bus_rdata=0xDEADBEEF -> bus_be=4'b1111, rdata=0xDEADBEEF in DONE, lsu_stall high exactly 2 cycles.
REQ-038 LB addr=0x103, extendSign=1, bus_rdata=0x80000000 -> bus_be=4'b1000, rdata=0xFFFFFF80; LBU same -> rdata=0x00000080.
REQ-039 SH addr=0x202, wdata=0x1234ABCD -> bus_we=1, bus_addr=0x200, bus_be=4'b1100, bus_wdata=0xABCDABCD.
REQ-040 LW addr=0x101 -> misaligned pulse 1 cycle, no bus_req, rdata=0, DONE next cycle.
REQ-041 LW, bus_ack never asserted, WAIT_LIMIT=4 -> bus_err pulse after 4 REQ cycles, bus_req drops, rdata=0, lsu_stall low in DONE.
REQ-042 reset during REQ, then back-to-back SB 0x10/LH 0x12 -> outputs cleared, both accesses complete correctly in order.
